cdb_arbiter: RTL

//   Shares the K common data bus (CDB) ports among N functional-unit requesters (ALUs, mult, load).
//   It uses early-tag-broadcast (ETB) arbitration.
//   - A unit raises req one cycle before its result is ready. A granted unit advances and drives the CDB next cycle.
//   - An ungranted unit holds and re-requests.

---
 rtl/cdb_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to NUM_CDB of NUM_REQ early-tag-broadcast requesters per cycle,
// round-robin with escalation for requesters denied STARVE_LIMIT consecutive cycles.
module cdb_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int NUM_CDB      = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic                               flush,
    output logic [NUM_REQ-1:0]                 gnt,
    output logic [NUM_CDB-1:0]                 bcast_valid,
    output logic [NUM_CDB*$clog2(NUM_REQ)-1:0] bcast_sel,
    output logic [NUM_REQ-1:0]                 starving
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int SW = $clog2(NUM_CDB + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]         wait_q [NUM_REQ];
    logic [CW-1:0]         wait_d [NUM_REQ];
    logic [NUM_CDB-1:0]    bv_q, bv_d;
    logic [NUM_CDB*IW-1:0] sel_q, sel_d;
    logic [NUM_REQ-1:0]    starv_q, starv_d;
    logic [NUM_REQ-1:0]    gnt_c;

    // Pass 0 admits only saturated requesters, pass 1 fills remaining ports; both
    // scan from rr_ptr so escalated requesters also rotate among themselves.
    always_comb begin
        logic [IW-1:0] idx;
        logic [SW-1:0] nsel;
        gnt_c    = '0;
        bv_d     = '0;
        sel_d    = '0;
        rr_ptr_d = rr_ptr_q;
        idx      = '0;
        nsel     = '0;
        if (reset_n && !flush) begin
            for (int unsigned pass = 0; pass < 2; pass++) begin
                for (int unsigned off = 0; off < NUM_REQ; off++) begin
                    idx = IW'((32'(rr_ptr_q) + off) % NUM_REQ);
                    if (req[idx] && !gnt_c[idx] && nsel < SW'(NUM_CDB) &&
                        (pass == 1 || wait_q[idx] == LIMIT)) begin
                        gnt_c[idx] = 1'b1;
                        for (int unsigned j = 0; j < NUM_CDB; j++) begin
                            if (nsel == SW'(j)) begin
                                bv_d[j]          = 1'b1;
                                sel_d[j*IW +: IW] = idx;
                            end
                        end
                        nsel     = nsel + 1'b1;
                        rr_ptr_d = (32'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = '0;
            if (!flush && req[i] && !gnt_c[i]) begin
                wait_d[i] = (wait_q[i] == LIMIT) ? LIMIT : wait_q[i] + 1'b1;
            end
            starv_d[i] = (wait_d[i] == LIMIT);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
            bv_q     <= '0;
            sel_q    <= '0;
            starv_q  <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            bv_q     <= bv_d;
            sel_q    <= sel_d;
            starv_q  <= starv_d;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign gnt         = gnt_c;
    assign bcast_valid = bv_q;
    assign bcast_sel   = sel_q;
    assign starving    = starv_q;

endmodule
